// File: rtl/mult64_seq_pkg.sv
// Shared definitions for the sequential multiplier: FSM state type,
// default operand width and iteration counter width.
package mult64_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF) + 1;

endpackage

// File: rtl/mult64_seq_adder.sv
// Unsigned WIDTH-bit adder with carry-out; the single add stage of the
// shift-add multiplier.
module adder64
  import mult64_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mult64_seq.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per clock,
// WIDTH iterations, full 2*WIDTH-bit product split into prod_hi/prod_lo.
module mult64_seq
  import mult64_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH:0]     pp_q, pp_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic [2*WIDTH:0]     pp_step;
  logic [2*WIDTH:0]     pp_next;

  adder64 #(.WIDTH(WIDTH)) u_add (
    .a_i   (pp_q[2*WIDTH-1:WIDTH]),
    .b_i   (a_q),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  // One shift-add iteration: conditionally add the multiplicand into the
  // upper half (carry kept in the extra top bit), then shift right by one.
  always_comb begin
    pp_step = b_q[0] ? {add_cout, add_sum, pp_q[WIDTH-1:0]} : pp_q;
    pp_next = pp_step >> 1;
  end

  // Next-state and datapath control; abort takes priority over start and
  // over completion of the final iteration.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pp_d    = pp_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = BUSY;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          pp_d    = '0;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          pp_d  = pp_next;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            lo_d    = pp_next[WIDTH-1:0];
            hi_d    = pp_next[2*WIDTH-1:WIDTH];
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pp_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pp_q    <= pp_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = done_q;
  assign prod_lo = lo_q;
  assign prod_hi = hi_q;

endmodule

// File: tb/tb_mult64_seq.sv
// Self-checking bench for mult64_seq: products are queued when a start is
// driven and compared when done pulses.
module tb_mult64_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] prod_lo;
  logic [63:0] prod_hi;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb[$];

  mult64_seq #(.WIDTH(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .prod_lo(prod_lo),
    .prod_hi(prod_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (!reset && done) begin
      logic [127:0] exp;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got hi=%h lo=%h, required no done", prod_hi, prod_lo);
      end else begin
        exp = sb.pop_front();
        if ({prod_hi, prod_lo} !== exp) begin
          errors++;
          $display("FAIL sb_product: got %h_%h, required %h", prod_hi, prod_lo, exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  task automatic do_start(input logic [63:0] x, input logic [63:0] y, input bit push);
    a = x;
    b = y;
    start = 1'b1;
    if (push) sb.push_back(128'(x) * 128'(y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int nbusy, output bit got);
    nbusy = 0;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if ({prod_hi, prod_lo} !== 128'd0) begin
      errors++; $display("FAIL reset_prod: got %h_%h, required 0", prod_hi, prod_lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n; bit got;
    do_start(64'd3, 64'd5, 1'b1);
    run_until_done(100, n, got);
    checks++;
    if (!got || n != 64) begin
      errors++; $display("FAIL basic_latency: got done=%b busy_cycles=%0d, required 1 64", got, n);
    end
    checks++;
    if (busy !== 1'b0 || prod_lo !== 64'd15 || prod_hi !== 64'd0) begin
      errors++; $display("FAIL basic_result: got busy=%b hi=%h lo=%h, required 0 0 15", busy, prod_hi, prod_lo);
    end
  endtask

  task automatic test_max();
    int n; bit got;
    @(negedge clk);
    do_start('1, '1, 1'b1);
    run_until_done(100, n, got);
    checks++;
    if (!got || prod_lo !== 64'h0000_0000_0000_0001 || prod_hi !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++; $display("FAIL max_result: got done=%b hi=%h lo=%h, required fffffffffffffffe 1", got, prod_hi, prod_lo);
    end
  endtask

  task automatic test_start_ignored();
    int n; bit got; bit injected;
    @(negedge clk);
    do_start(64'd7, 64'd9, 1'b1);
    run_until_done(100, n, got);
    @(negedge clk);
    do_start(64'd2, 64'd2, 1'b1);
    n = 0; got = 1'b0; injected = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (busy) n++;
      if (n == 10 && !injected) begin
        injected = 1'b1;
        a = 64'd100;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    checks++;
    if (!got || n != 64 || prod_lo !== 64'd4) begin
      errors++; $display("FAIL ignore_start: got done=%b busy_cycles=%0d lo=%0d, required 1 64 4", got, n, prod_lo);
    end
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL ignore_no_queue: got busy_cycles=%0d after done, required 0", n);
    end
  endtask

  task automatic test_abort(input int abort_at);
    int n; int ndone; bit got; bit aborted;
    @(negedge clk);
    do_start(64'd7, 64'd9, 1'b1);
    run_until_done(100, n, got);
    @(negedge clk);
    do_start(64'd4, 64'd4, 1'b0);
    n = 0; aborted = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        aborted = 1'b1;
        break;
      end
    end
    checks++;
    if (!aborted || busy !== 1'b0 || done !== 1'b0 || prod_lo !== 64'd63) begin
      errors++;
      $display("FAIL abort_at_%0d: got aborted=%b busy=%b done=%b lo=%0d, required 1 0 0 63",
               abort_at, aborted, busy, done, prod_lo);
    end
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || prod_lo !== 64'd63) begin
      errors++; $display("FAIL abort_hold_%0d: got dones=%0d lo=%0d, required 0 63", abort_at, ndone, prod_lo);
    end
  endtask

  task automatic test_abort_with_start();
    int n;
    @(negedge clk);
    a = 64'd8; b = 64'd8; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; abort = 1'b0; end
    n = 0;
    repeat (70) begin
      @(negedge clk);
      if (busy || done) n++;
    end
    checks++;
    if (n != 0 || prod_lo !== 64'd63) begin
      errors++; $display("FAIL abort_start_idle: got active_cycles=%0d lo=%0d, required 0 63", n, prod_lo);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit got;
    @(negedge clk);
    do_start(64'd11, 64'd13, 1'b1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 30) break;
    end
    reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({busy, done} !== 2'b00 || {prod_hi, prod_lo} !== 128'd0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, prod_hi, prod_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_start(64'd6, 64'd7, 1'b1);
    run_until_done(100, n, got);
    checks++;
    if (!got || n != 64 || prod_lo !== 64'd42) begin
      errors++; $display("FAIL reset_restart: got done=%b busy_cycles=%0d lo=%0d, required 1 64 42", got, n, prod_lo);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit got;
    @(negedge clk);
    do_start(64'd5, 64'd5, 1'b1);
    run_until_done(100, n, got);
    checks++;
    if (!got || prod_lo !== 64'd25) begin
      errors++; $display("FAIL b2b_first: got done=%b lo=%0d, required 1 25", got, prod_lo);
    end
    do_start(64'd2, 64'd3, 1'b1);
    run_until_done(100, n, got);
    checks++;
    if (!got || n != 64 || prod_lo !== 64'd6) begin
      errors++; $display("FAIL b2b_second: got done=%b busy_cycles=%0d lo=%0d, required 1 64 6", got, n, prod_lo);
    end
  endtask

  task automatic test_random();
    int n; bit got;
    logic [63:0] x, y;
    for (int k = 0; k < 5; k++) begin
      x = (k == 0) ? 64'd0 : {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      @(negedge clk);
      do_start(x, y, 1'b1);
      run_until_done(100, n, got);
      checks++;
      if (!got || n != 64) begin
        errors++; $display("FAIL random_latency_%0d: got done=%b busy_cycles=%0d, required 1 64", k, got, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_start_ignored();
    test_abort(10);
    test_abort(64);
    test_abort_with_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult64_seq.md
MULT64_SEQ -- requirements
Module: mult64_seq

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled on the rising edge of clk.
REQ-005 abort  input  1  pipeline flush; cancels an in-flight multiply.
REQ-006 a  input  WIDTH  multiplicand, unsigned, captured when start is accepted.
REQ-007 b  input  WIDTH  multiplier, unsigned, captured when start is accepted.
REQ-008 busy  output  1  high while an iteration is in progress.
REQ-009 done  output  1  one-cycle pulse: result registers have just been updated.
REQ-010 prod_lo  output  WIDTH  low half of a*b (MUL), feeds an input of the ALU result select.
REQ-011 prod_hi  output  WIDTH  high half of a*b (UMULH), feeds an input of the ALU result select.

Function
REQ-012 The block SHALL use radix-2 shift-add: one multiplier bit per cycle, WIDTH iterations.
REQ-013 The state machine SHALL have exactly the states IDLE and BUSY.
REQ-014 IDLE transitions to BUSY on start=1 and abort=0. The operands are latched on that edge and the iteration counter and partial product are cleared.
REQ-015 In BUSY, each edge SHALL add the multiplicand to the upper partial product when the current multiplier LSB is 1. The carry-out SHALL be kept in the partial product (2*WIDTH+1 bits internal). The register SHALL then shift right by 1.
REQ-016 Latency: if start is accepted at edge E0, BUSY SHALL run from edge E1 through edge EWIDTH. At edge EWIDTH, prod_hi/prod_lo SHALL update, done=1 for one cycle, and the state SHALL return to IDLE.
REQ-017 busy SHALL equal 1 exactly while the state is BUSY.
REQ-018 A start while BUSY SHALL be ignored: operands unchanged, no queueing.
REQ-019 A start in the done cycle (IDLE, done=1) SHALL be accepted, giving back-to-back operation with no bubble.
REQ-020 abort=1 in BUSY SHALL return the state to IDLE on the next edge. done SHALL stay 0 and prod_hi/prod_lo SHALL keep their previous values.
REQ-021 abort=1 together with start=1 in IDLE: abort SHALL win and start is dropped.
REQ-022 abort on the same edge that would complete the multiply (iteration WIDTH): abort SHALL win, with no done and no result update.
REQ-023 prod_hi/prod_lo SHALL change only on a done edge and SHALL hold otherwise.
REQ-024 Zero operands SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-025 reset=1 SHALL immediately force the state to IDLE, busy=0, done=0, prod_lo=0, prod_hi=0, with the counter and internal operands cleared.
REQ-026 reset asserted mid-operation SHALL discard the in-flight multiply. After release, the first accepted start SHALL behave exactly as from power-up.
REQ-027 No output SHALL be X after reset asserts.

Structure
REQ-028 A shared CPU package SHALL hold the state enum type (IDLE, BUSY), the WIDTH default of 64 and the counter width constant (clog2 of WIDTH plus 1).
REQ-029 The add step SHALL be one sub-module, adder64: a WIDTH-bit unsigned add with carry-out, instantiated once.
REQ-030 All state SHALL be in flops clocked by clk with async reset. The next-state and datapath logic SHALL be combinational.

Verification
REQ-031 a=3, b=5, start pulse -> busy for 64 cycles, done at edge 64, prod_lo=15, prod_hi=0.
REQ-032 a=b=0xFFFF_FFFF_FFFF_FFFF -> prod_lo=0x0000_0000_0000_0001, prod_hi=0xFFFF_FFFF_FFFF_FFFE.
REQ-033 Finish 7*9. Then start a=2, b=2 and assert start again at BUSY cycle 10 with a=100 -> done at edge 64 after the first start, prod_lo=4; the second start is ignored.
REQ-034 Prior result 63. Start 4*4, abort at BUSY cycle 10 -> no done, busy=0 next cycle, prod_lo stays 63.
REQ-035 Assert reset at BUSY cycle 30 -> busy, done, prod_lo and prod_hi all 0 immediately. A new start 6*7 gives prod_lo=42 after 64 cycles.
REQ-036 Start 2*3 in the done cycle of 5*5 -> prod_lo=25 at the first done. A second done exactly 64 edges later gives prod_lo=6.
